// File: rtl/receiver2b.sv
// Two-frame (16-bit) oversampling serial receiver: start/8 data/stop per frame, MSB-first word assembly.
// Build option: define RX_SYNC_EN to insert a two-flop rx synchronizer ahead of sampling.
module receiver2b #(
   parameter int OVERSAMPLE = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [15:0] data,
   output logic        data_received,
   output logic        frame_error,
   output logic [1:0]  state_out
);

   localparam int HALF = OVERSAMPLE / 2;
   localparam logic [6:0] HALF_LAST = 7'(HALF - 1);
   localparam logic [6:0] BIT_LAST  = 7'(OVERSAMPLE - 1);
   localparam logic [6:0] GAP_LAST  = 7'(2 * OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state;
   logic [6:0]  cnt;
   logic [2:0]  bit_cnt;
   logic [15:0] shreg;
   logic        frame_idx;
   logic        armed;
   logic        word_vld_p0;
   logic        rx_samp;
   logic        rx_prev;
   logic        fall_edge;

   // input stage: rx_samp feeds every sampling point, rx_prev is its one-cycle history
`ifdef RX_SYNC_EN
   logic rx_p0, rx_p1, rx_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   assign rx_samp = rx_p1;
   assign rx_prev = rx_p2;
`else
   logic rx_p0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_p0 <= 1'b1;
      else       rx_p0 <= rx;
   end

   assign rx_samp = rx;
   assign rx_prev = rx_p0;
`endif

   // armed guards against treating a line already low (after reset or a bad stop) as a start edge
   assign fall_edge = armed & rx_prev & ~rx_samp;
   assign state_out = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         frame_idx     <= 1'b0;
         armed         <= 1'b0;
         word_vld_p0   <= 1'b0;
         data          <= '0;
         data_received <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         data_received <= 1'b0;
         frame_error   <= 1'b0;
         word_vld_p0   <= 1'b0;
         if (rx_samp) armed <= 1'b1;

         // output stage: commit the assembled word one clock after the frame-1 stop sample
         if (word_vld_p0) begin
            data          <= shreg;
            data_received <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (fall_edge) begin
                  state <= START;
                  cnt   <= '0;
               end else if (frame_idx) begin
                  if (cnt == GAP_LAST) begin
                     frame_error <= 1'b1;
                     frame_idx   <= 1'b0;
                     shreg       <= '0;
                     cnt         <= '0;
                  end else begin
                     cnt <= cnt + 7'd1;
                  end
               end
            end

            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_samp) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 7'd1;
               end
            end

            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shreg   <= {shreg[14:0], rx_samp};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + 7'd1;
               end
            end

            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (rx_samp) begin
                     if (frame_idx) begin
                        word_vld_p0 <= 1'b1;
                        frame_idx   <= 1'b0;
                     end else begin
                        frame_idx <= 1'b1;
                     end
                  end else begin
                     frame_error <= 1'b1;
                     frame_idx   <= 1'b0;
                     shreg       <= '0;
                     armed       <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 7'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_receiver2b.sv
// Directed bench for receiver2b: word reception, false start, bad stop, missing frame, reset mid-word.
module tb_receiver2b;
   parameter int OS = 16;
`ifdef RX_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif
   // edge numbers relative to the edge after which the start bit is driven
   localparam int TS0 = 1 + OS / 2 + 9 * OS + SL;   // frame-0 stop sample (153 at OS=16)
   localparam int TDR = 10 * OS + TS0 + 1;          // data_received of a word (314 at OS=16)
   localparam int LOW = OS / 4 + 1;                 // false-start low time (5 at OS=16)

   logic        clk;
   logic        reset;
   logic        rx;
   logic [15:0] data;
   logic        data_received;
   logic        frame_error;
   logic [1:0]  state_out;

   receiver2b #(.OVERSAMPLE(OS)) dut (
      .clk(clk),
      .reset(reset),
      .rx(rx),
      .data(data),
      .data_received(data_received),
      .frame_error(frame_error),
      .state_out(state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   int dr_cnt = 0, fe_cnt = 0, both_cnt = 0, dr_cyc = -1, fe_cyc = -1;
   int n_cmp = 0, n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_received === 1'b1) begin dr_cnt++; dr_cyc = cyc; end
      if (frame_error === 1'b1) begin fe_cnt++; fe_cyc = cyc; end
      if (data_received === 1'b1 && frame_error === 1'b1) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(OS);
      for (int i = 7; i >= 0; i--) begin
         rx = b[i];
         tick(OS);
      end
      rx = stop;
      tick(OS);
   endtask

   int t0, dr0, fe0, saw_start, saw_bad;

   initial begin
      rx = 1'b1;
      reset = 1'b1;
      tick(3);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_data", 32'(data), 32'h0000);
      check("rst_dr", 32'(data_received), 32'd0);
      check("rst_fe", 32'(frame_error), 32'd0);
      reset = 1'b0;
      tick(5);

      // word A53C
      dr0 = dr_cnt; fe0 = fe_cnt; t0 = cyc;
      send_frame(8'hA5, 1'b1);
      send_frame(8'h3C, 1'b1);
      rx = 1'b1;
      tick(OS);
      check("w1_data", 32'(data), 32'hA53C);
      check("w1_dr_count", 32'(dr_cnt - dr0), 32'd1);
      check("w1_dr_latency", 32'(dr_cyc - t0), 32'(TDR));
      check("w1_fe_count", 32'(fe_cnt - fe0), 32'd0);
      check("w1_state", 32'(state_out), 32'd0);

      // false start
      dr0 = dr_cnt; fe0 = fe_cnt;
      saw_start = 0; saw_bad = 0;
      rx = 1'b0;
      for (int i = 1; i <= OS; i++) begin
         tick(1);
         if (i == LOW) rx = 1'b1;
         if (state_out == 2'd1) saw_start++;
         if (state_out > 2'd1) saw_bad++;
      end
      tick(OS);
      check("fs_start_cycles", 32'(saw_start), 32'(OS / 2));
      check("fs_no_data_state", 32'(saw_bad), 32'd0);
      check("fs_state_idle", 32'(state_out), 32'd0);
      check("fs_dr_count", 32'(dr_cnt - dr0), 32'd0);
      check("fs_fe_count", 32'(fe_cnt - fe0), 32'd0);
      check("fs_data", 32'(data), 32'hA53C);

      // bad stop bit on frame 0
      dr0 = dr_cnt; fe0 = fe_cnt; t0 = cyc;
      send_frame(8'hA5, 1'b0);
      rx = 1'b1;
      tick(2 * OS);
      check("bs_fe_count", 32'(fe_cnt - fe0), 32'd1);
      check("bs_fe_time", 32'(fe_cyc - t0), 32'(TS0));
      check("bs_dr_count", 32'(dr_cnt - dr0), 32'd0);
      check("bs_data_kept", 32'(data), 32'hA53C);

      dr0 = dr_cnt; fe0 = fe_cnt; t0 = cyc;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      rx = 1'b1;
      tick(OS);
      check("w2_data", 32'(data), 32'h00FF);
      check("w2_dr_count", 32'(dr_cnt - dr0), 32'd1);
      check("w2_dr_latency", 32'(dr_cyc - t0), 32'(TDR));
      check("w2_fe_count", 32'(fe_cnt - fe0), 32'd0);

      // frame 0 with no second frame
      dr0 = dr_cnt; fe0 = fe_cnt; t0 = cyc;
      send_frame(8'h3C, 1'b1);
      rx = 1'b1;
      tick(2 * OS + 8);
      check("to_fe_count", 32'(fe_cnt - fe0), 32'd1);
      check("to_fe_time", 32'(fe_cyc - t0), 32'(TS0 + 2 * OS));
      check("to_dr_count", 32'(dr_cnt - dr0), 32'd0);
      check("to_data_kept", 32'(data), 32'h00FF);
      check("to_state", 32'(state_out), 32'd0);

      dr0 = dr_cnt; fe0 = fe_cnt;
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      rx = 1'b1;
      tick(OS);
      check("w3_data", 32'(data), 32'h1234);
      check("w3_dr_count", 32'(dr_cnt - dr0), 32'd1);
      check("w3_fe_count", 32'(fe_cnt - fe0), 32'd0);

      // reset in the middle of frame 1
      dr0 = dr_cnt; fe0 = fe_cnt;
      send_frame(8'h5A, 1'b1);
      rx = 1'b0;
      tick(OS);
      tick(OS / 2);
      reset = 1'b1;
      #1;
      check("mr_state", 32'(state_out), 32'd0);
      check("mr_data", 32'(data), 32'h0000);
      check("mr_dr", 32'(data_received), 32'd0);
      check("mr_fe", 32'(frame_error), 32'd0);
      tick(3);
      reset = 1'b0;
      tick(3 * OS);
      check("mr_wait_edge", 32'(state_out), 32'd0);
      check("mr_dr_count", 32'(dr_cnt - dr0), 32'd0);
      check("mr_fe_count", 32'(fe_cnt - fe0), 32'd0);
      check("mr_data_held", 32'(data), 32'h0000);

      rx = 1'b1;
      tick(OS);
      dr0 = dr_cnt; fe0 = fe_cnt; t0 = cyc;
      send_frame(8'hC3, 1'b1);
      send_frame(8'hA5, 1'b1);
      rx = 1'b1;
      tick(OS);
      check("w4_data", 32'(data), 32'hC3A5);
      check("w4_dr_count", 32'(dr_cnt - dr0), 32'd1);
      check("w4_dr_latency", 32'(dr_cyc - t0), 32'(TDR));
      check("w4_fe_count", 32'(fe_cnt - fe0), 32'd0);

      check("never_both", 32'(both_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
